// File: rtl/stage_2.sv
// stage_2: instruction decode stage.
// Decodes the incoming instruction, reads rs/rt from a 32x32 register file
// (with write-through bypass and external operand forwarding), registers the
// decoded controls and operands for the next stage, and maintains an 8-bit
// stack pointer that CALL decrements and RET increments.
module stage_2 (
  input  logic        clk,
  input  logic        reset,
  input  logic        En_Pipeline,
  input  logic [31:0] Instruction,
  input  logic [4:0]  Addr_Write_Reg,
  input  logic        Reg_Write_En_in,
  input  logic [31:0] data_in,
  input  logic [31:0] Forward_Data_in,
  input  logic [1:0]  Forward_Selector,
  output logic [7:0]  SP_Data,
  output logic [5:0]  ALU_Op_Code_out,
  output logic        ALU_src_out,
  output logic        En_Integer_out,
  output logic        En_Float_out,
  output logic        Memory_Read_out,
  output logic        Memory_Write_out,
  output logic        Reg_Write_En_out,
  output logic        WB_Mux_sel_out,
  output logic        CALL_flag_out,
  output logic        RET_flag_out,
  output logic        BR_flag_out,
  output logic        JMP_flag_out,
  output logic [4:0]  Addr_Write_Reg_out,
  output logic [31:0] data1_out,
  output logic [31:0] data2_out,
  output logic [15:0] imm_out,
  output logic        F_Read_Reg_En
);

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int SP_W   = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_FLOAT = 6'h11;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_STORE = 6'h2B;
  localparam logic [5:0] OP_BR    = 6'h04;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_CALL  = 6'h3E;
  localparam logic [5:0] OP_RET   = 6'h3D;

  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_SUB  = 6'h22;

  localparam logic [SP_W-1:0] SP_RESET = 8'hFF;

  // Decoded control bundle carried from decode into the pipeline register.
  typedef struct packed {
    logic [5:0] alu_op;
    logic       alu_src;
    logic       en_int;
    logic       en_flt;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       wb_sel;
    logic       call;
    logic       ret;
    logic       br;
    logic       jmp;
    logic [4:0] dest;
  } ctrl_t;

  // Full instruction decode; the all-zero word and unknown opcodes give NOP.
  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t c;
    c = '0;
    if (ins != 32'h0) begin
      case (ins[31:26])
        OP_RTYPE: begin
          c.alu_op = ins[5:0];
          c.en_int = 1'b1;
          c.reg_wr = 1'b1;
          c.dest   = ins[15:11];
        end
        OP_FLOAT: begin
          c.alu_op = ins[5:0];
          c.en_flt = 1'b1;
          c.reg_wr = 1'b1;
          c.dest   = ins[15:11];
        end
        OP_ADDI: begin
          c.alu_op  = ALU_ADD;
          c.alu_src = 1'b1;
          c.en_int  = 1'b1;
          c.reg_wr  = 1'b1;
          c.dest    = ins[20:16];
        end
        OP_LOAD: begin
          c.alu_op  = ALU_ADD;
          c.alu_src = 1'b1;
          c.mem_rd  = 1'b1;
          c.reg_wr  = 1'b1;
          c.wb_sel  = 1'b1;
          c.dest    = ins[20:16];
        end
        OP_STORE: begin
          c.alu_op  = ALU_ADD;
          c.alu_src = 1'b1;
          c.mem_wr  = 1'b1;
        end
        OP_BR: begin
          c.alu_op = ALU_SUB;
          c.br     = 1'b1;
        end
        OP_JMP:  c.jmp  = 1'b1;
        OP_CALL: c.call = 1'b1;
        OP_RET:  c.ret  = 1'b1;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // True for instruction classes that consume rs/rt operands.
  function automatic logic reads_regs(input logic [31:0] ins);
    logic r;
    r = 1'b0;
    if (ins != 32'h0) begin
      case (ins[31:26])
        OP_RTYPE, OP_FLOAT, OP_ADDI, OP_LOAD, OP_STORE, OP_BR: r = 1'b1;
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Stack pointer step with modulo-256 wrap in both directions.
  function automatic logic [SP_W-1:0] sp_step(input logic [SP_W-1:0] sp,
                                              input logic dec,
                                              input logic inc);
    logic [SP_W-1:0] n;
    n = sp;
    if (dec)      n = sp - 8'd1;
    else if (inc) n = sp + 8'd1;
    return n;
  endfunction

  logic [DATA_W-1:0] regs [REG_N];

  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  ctrl_t             ctrl_p0;
  logic [DATA_W-1:0] data1_p0;
  logic [DATA_W-1:0] data2_p0;

  ctrl_t             ctrl_p1;
  logic [DATA_W-1:0] data1_p1;
  logic [DATA_W-1:0] data2_p1;
  logic [15:0]       imm_p1;
  logic [SP_W-1:0]   sp_p1;

  // ---- stage p0: decode and operand fetch (combinational) ----
  assign rs_p0         = Instruction[25:21];
  assign rt_p0         = Instruction[20:16];
  assign ctrl_p0       = decode(Instruction);
  assign F_Read_Reg_En = reads_regs(Instruction);

  // Operand read with write-through bypass, then external forwarding override.
  always_comb begin
    data1_p0 = regs[rs_p0];
    data2_p0 = regs[rt_p0];
    if (Reg_Write_En_in && (Addr_Write_Reg == rs_p0)) data1_p0 = data_in;
    if (Reg_Write_En_in && (Addr_Write_Reg == rt_p0)) data2_p0 = data_in;
    if (Forward_Selector[0]) data1_p0 = Forward_Data_in;
    if (Forward_Selector[1]) data2_p0 = Forward_Data_in;
  end

  // Register file write port; runs regardless of pipeline stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (Reg_Write_En_in) begin
      regs[Addr_Write_Reg] <= data_in;
    end
  end

  // ---- stage p1: decode/operand pipeline register ----
  // Loads only when the pipeline is enabled; otherwise holds for the stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1  <= '0;
      data1_p1 <= '0;
      data2_p1 <= '0;
      imm_p1   <= '0;
    end else if (En_Pipeline) begin
      ctrl_p1  <= ctrl_p0;
      data1_p1 <= data1_p0;
      data2_p1 <= data2_p0;
      imm_p1   <= Instruction[15:0];
    end
  end

  // Stack pointer: CALL pushes (decrement), RET pops (increment).
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_p1 <= SP_RESET;
    end else if (En_Pipeline) begin
      sp_p1 <= sp_step(sp_p1, ctrl_p0.call, ctrl_p0.ret);
    end
  end

  assign SP_Data            = sp_p1;
  assign ALU_Op_Code_out    = ctrl_p1.alu_op;
  assign ALU_src_out        = ctrl_p1.alu_src;
  assign En_Integer_out     = ctrl_p1.en_int;
  assign En_Float_out       = ctrl_p1.en_flt;
  assign Memory_Read_out    = ctrl_p1.mem_rd;
  assign Memory_Write_out   = ctrl_p1.mem_wr;
  assign Reg_Write_En_out   = ctrl_p1.reg_wr;
  assign WB_Mux_sel_out     = ctrl_p1.wb_sel;
  assign CALL_flag_out      = ctrl_p1.call;
  assign RET_flag_out       = ctrl_p1.ret;
  assign BR_flag_out        = ctrl_p1.br;
  assign JMP_flag_out       = ctrl_p1.jmp;
  assign Addr_Write_Reg_out = ctrl_p1.dest;
  assign data1_out          = data1_p1;
  assign data2_out          = data2_p1;
  assign imm_out            = imm_p1;

endmodule

// File: tb/tb_stage_2.sv
// tb_stage_2: directed plus randomized checks of stage_2 against a
// behavioural model (register array, integer stack pointer, decode table).
module tb_stage_2;

  logic        clk = 1'b0;
  logic        reset;
  logic        En_Pipeline;
  logic [31:0] Instruction;
  logic [4:0]  Addr_Write_Reg;
  logic        Reg_Write_En_in;
  logic [31:0] data_in;
  logic [31:0] Forward_Data_in;
  logic [1:0]  Forward_Selector;
  logic [7:0]  SP_Data;
  logic [5:0]  ALU_Op_Code_out;
  logic        ALU_src_out, En_Integer_out, En_Float_out;
  logic        Memory_Read_out, Memory_Write_out, Reg_Write_En_out, WB_Mux_sel_out;
  logic        CALL_flag_out, RET_flag_out, BR_flag_out, JMP_flag_out;
  logic [4:0]  Addr_Write_Reg_out;
  logic [31:0] data1_out, data2_out;
  logic [15:0] imm_out;
  logic        F_Read_Reg_En;

  always #5 clk = ~clk;

  stage_2 dut (
    .clk(clk), .reset(reset), .En_Pipeline(En_Pipeline), .Instruction(Instruction),
    .Addr_Write_Reg(Addr_Write_Reg), .Reg_Write_En_in(Reg_Write_En_in), .data_in(data_in),
    .Forward_Data_in(Forward_Data_in), .Forward_Selector(Forward_Selector),
    .SP_Data(SP_Data), .ALU_Op_Code_out(ALU_Op_Code_out), .ALU_src_out(ALU_src_out),
    .En_Integer_out(En_Integer_out), .En_Float_out(En_Float_out),
    .Memory_Read_out(Memory_Read_out), .Memory_Write_out(Memory_Write_out),
    .Reg_Write_En_out(Reg_Write_En_out), .WB_Mux_sel_out(WB_Mux_sel_out),
    .CALL_flag_out(CALL_flag_out), .RET_flag_out(RET_flag_out),
    .BR_flag_out(BR_flag_out), .JMP_flag_out(JMP_flag_out),
    .Addr_Write_Reg_out(Addr_Write_Reg_out), .data1_out(data1_out), .data2_out(data2_out),
    .imm_out(imm_out), .F_Read_Reg_En(F_Read_Reg_En)
  );

  // Expected decode of one instruction, straight from the opcode table.
  typedef struct packed {
    logic [5:0] alu;
    logic src, ei, ef, mr, mw, rw, wb, call, ret, br, jmp;
    logic [4:0] dest;
    logic rd;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_rf [32];
  int          m_sp;
  exp_t        m_ctl;
  logic [31:0] m_d1, m_d2;
  logic [15:0] m_imm;

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    logic [5:0] op;
    e  = '0;
    op = ins[31:26];
    if (ins == 32'h0) return e;
    if (op == 6'h00 || op == 6'h11) begin
      e.alu = ins[5:0]; e.rw = 1; e.dest = ins[15:11]; e.rd = 1;
      if (op == 6'h00) e.ei = 1; else e.ef = 1;
    end else if (op == 6'h08) begin
      e.alu = 6'h20; e.src = 1; e.ei = 1; e.rw = 1; e.dest = ins[20:16]; e.rd = 1;
    end else if (op == 6'h23) begin
      e.alu = 6'h20; e.src = 1; e.mr = 1; e.rw = 1; e.wb = 1; e.dest = ins[20:16]; e.rd = 1;
    end else if (op == 6'h2B) begin
      e.alu = 6'h20; e.src = 1; e.mw = 1; e.rd = 1;
    end else if (op == 6'h04) begin
      e.alu = 6'h22; e.br = 1; e.rd = 1;
    end else if (op == 6'h02) e.jmp = 1;
    else if (op == 6'h3E) e.call = 1;
    else if (op == 6'h3D) e.ret = 1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t f;
    f = ref_decode(Instruction);
    chk("sp",     {24'h0, SP_Data}, m_sp[31:0]);
    chk("alu_op", {26'h0, ALU_Op_Code_out}, {26'h0, m_ctl.alu});
    chk("ctrl",   {20'h0, ALU_src_out, En_Integer_out, En_Float_out, Memory_Read_out,
                   Memory_Write_out, Reg_Write_En_out, WB_Mux_sel_out, CALL_flag_out,
                   RET_flag_out, BR_flag_out, JMP_flag_out, 1'b0},
                  {20'h0, m_ctl.src, m_ctl.ei, m_ctl.ef, m_ctl.mr, m_ctl.mw, m_ctl.rw,
                   m_ctl.wb, m_ctl.call, m_ctl.ret, m_ctl.br, m_ctl.jmp, 1'b0});
    chk("dest",   {27'h0, Addr_Write_Reg_out}, {27'h0, m_ctl.dest});
    chk("data1",  data1_out, m_d1);
    chk("data2",  data2_out, m_d2);
    chk("imm",    {16'h0, imm_out}, {16'h0, m_imm});
    chk("f_read", {31'h0, F_Read_Reg_En}, {31'h0, f.rd});
  endtask

  // One clock: compute the model's next state from the inputs present
  // before the edge, then advance the clock and apply it.
  task automatic step();
    exp_t d;
    logic [31:0] a, b;
    d = ref_decode(Instruction);
    a = (Reg_Write_En_in && Addr_Write_Reg == Instruction[25:21]) ? data_in : m_rf[Instruction[25:21]];
    b = (Reg_Write_En_in && Addr_Write_Reg == Instruction[20:16]) ? data_in : m_rf[Instruction[20:16]];
    if (Forward_Selector[0]) a = Forward_Data_in;
    if (Forward_Selector[1]) b = Forward_Data_in;
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_sp = 255; m_ctl = '0; m_d1 = 0; m_d2 = 0; m_imm = 0;
    end else begin
      if (Reg_Write_En_in) m_rf[Addr_Write_Reg] = data_in;
      if (En_Pipeline) begin
        m_ctl = d; m_ctl.rd = 1'b0; m_d1 = a; m_d2 = b; m_imm = Instruction[15:0];
        if (d.call) m_sp = (m_sp + 255) % 256;
        if (d.ret)  m_sp = (m_sp + 1) % 256;
      end
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
    Instruction = 32'h0; Reg_Write_En_in = 1; Addr_Write_Reg = a; data_in = v;
    step();
    Reg_Write_En_in = 0;
  endtask

  initial begin
    logic [31:0] r, r2;
    logic [5:0]  ops [10];
    ops = '{6'h00, 6'h11, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3E, 6'h3D, 6'h3F};
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_sp = 255; m_ctl = '0; m_d1 = 0; m_d2 = 0; m_imm = 0;

    reset = 1; En_Pipeline = 1; Instruction = 0; Addr_Write_Reg = 0; Reg_Write_En_in = 0;
    data_in = 0; Forward_Data_in = 0; Forward_Selector = 0;
    step(); step();
    reset = 0;
    step();
    chk("reset_sp", {24'h0, SP_Data}, 32'hFF);
    chk("reset_d1", data1_out, 32'h0);
    check_all();

    // CALL three times
    Instruction = 32'hF8000063;
    step(); chk("call_sp1", {24'h0, SP_Data}, 32'hFE);
    step(); chk("call_sp2", {24'h0, SP_Data}, 32'hFD);
    step(); chk("call_sp3", {24'h0, SP_Data}, 32'hFC);
    chk("call_flag", {31'h0, CALL_flag_out}, 32'h1);
    chk("call_imm", {16'h0, imm_out}, 32'h63);
    chk("call_rw", {31'h0, Reg_Write_En_out}, 32'h0);
    check_all();

    // RET three times
    Instruction = 32'hF4000000;
    step(); chk("ret_sp1", {24'h0, SP_Data}, 32'hFD);
    step(); chk("ret_sp2", {24'h0, SP_Data}, 32'hFE);
    step(); chk("ret_sp3", {24'h0, SP_Data}, 32'hFF);
    chk("ret_flag", {31'h0, RET_flag_out}, 32'h1);
    check_all();

    write_reg(5'd0, 32'd2); write_reg(5'd5, 32'd7);
    write_reg(5'd2, 32'd18); write_reg(5'd3, 32'd9);

    Instruction = 32'h00402804;
    #1 chk("rtype_fread", {31'h0, F_Read_Reg_En}, 32'h1);
    step();
    chk("rtype_d1", data1_out, 32'd18);
    chk("rtype_d2", data2_out, 32'd2);
    chk("rtype_alu", {26'h0, ALU_Op_Code_out}, 32'h04);
    chk("rtype_dest", {27'h0, Addr_Write_Reg_out}, 32'd5);
    chk("rtype_rw_ei", {30'h0, Reg_Write_En_out, En_Integer_out}, 32'h3);
    check_all();

    Instruction = 32'h00E21804;
    step();
    chk("r7_d1", data1_out, 32'h0);
    chk("r7_d2", data2_out, 32'd18);
    chk("r7_dest", {27'h0, Addr_Write_Reg_out}, 32'd3);
    Forward_Selector = 2'b01; Forward_Data_in = 32'hDEADBEEF;
    step();
    chk("fwd_d1", data1_out, 32'hDEADBEEF);
    chk("fwd_d2", data2_out, 32'd18);
    check_all();
    Forward_Selector = 2'b11; Forward_Data_in = 32'h0BADF00D;
    step();
    chk("fwd_both", data2_out, 32'h0BADF00D);
    check_all();
    Forward_Selector = 2'b00;

    // Same-cycle write/read of R7 returns the write data
    Reg_Write_En_in = 1; Addr_Write_Reg = 5'd7; data_in = 32'h55;
    step();
    chk("bypass_d1", data1_out, 32'h55);
    check_all();

    // Stall with CALL present; write R9 during the stall
    En_Pipeline = 0; Instruction = 32'hF8000063;
    Addr_Write_Reg = 5'd9; data_in = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_sp", {24'h0, SP_Data}, 32'hFF);
      chk("stall_d1", data1_out, 32'h55);
      chk("stall_call", {31'h0, CALL_flag_out}, 32'h0);
      check_all();
    end
    En_Pipeline = 1; Reg_Write_En_in = 0;
    Instruction = {6'h00, 5'd9, 5'd0, 5'd1, 5'd0, 6'h20};
    step();
    chk("stall_wr_r9", data1_out, 32'h1234);
    check_all();

    // SP wrap in both directions
    Instruction = 32'hF4000000;
    step(); chk("sp_wrap_up", {24'h0, SP_Data}, 32'h00);
    Instruction = 32'hF8000000;
    step(); chk("sp_wrap_dn", {24'h0, SP_Data}, 32'hFF);
    check_all();

    // Reset overrides enable and register writes
    reset = 1; Reg_Write_En_in = 1; Addr_Write_Reg = 5'd4; data_in = 32'd77;
    step();
    chk("rst_ovr_sp", {24'h0, SP_Data}, 32'hFF);
    chk("rst_ovr_call", {31'h0, CALL_flag_out}, 32'h0);
    reset = 0; Reg_Write_En_in = 0;
    Instruction = {6'h00, 5'd4, 5'd2, 5'd1, 5'd0, 6'h20};
    step();
    chk("rst_r4", data1_out, 32'h0);
    chk("rst_r2", data2_out, 32'h0);
    check_all();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r  = $urandom;
      r2 = $urandom;
      Instruction      = ($urandom_range(0, 19) == 0) ? 32'h0 : {ops[$urandom_range(0, 9)], r[25:0]};
      En_Pipeline      = ($urandom_range(0, 3) != 0);
      Reg_Write_En_in  = r2[0];
      Addr_Write_Reg   = (r2[1] ? Instruction[25:21] : r2[6:2]);
      data_in          = $urandom;
      Forward_Selector = r2[8:7];
      Forward_Data_in  = $urandom;
      reset            = ($urandom_range(0, 59) == 0);
      step();
      check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
